iomem_arbiter: RTL
==================

IOMEM_ARBITER -- requirements
Module: iomem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum slave wait in cycles before an error response is forced; legal range 2..65535.
REQ-002 Parameter ERR_RDATA, default 32'hFFFF_FFFF: read data returned on a timed-out transfer.
REQ-003 clk  in  1  single clock; all state advances on its rising edge.
REQ-004 resetn  in  1  reset, asynchronous assert, active-low.
REQ-005 m0_valid, m1_valid  in  1 each  requester transfer request, held high until the matching ready.
REQ-006 m0_wstrb, m1_wstrb  in  4 each  byte write strobes; all-zero means read.
REQ-007 m0_addr, m1_addr  in  32 each  byte address.
REQ-008 m0_wdata, m1_wdata  in  32 each  write data.
REQ-009 m0_ready, m1_ready  out  1 each  one-cycle completion pulse to the requester.
REQ-010 m0_rdata, m1_rdata  out  32 each  read data, valid while the matching ready is high.
REQ-011 s_valid  out  1  request to the shared iomem slave port.
REQ-012 s_wstrb  out  4; s_addr  out  32; s_wdata  out  32; these carry the command of the granted requester.
REQ-013 s_ready  in  1  slave completion; s_rdata  in  32  slave read data.
REQ-014 grant  out  1  index of the current or last owner (0 = m0); busy  out  1  high outside IDLE.
REQ-015 timeout_err  out  1  one-cycle pulse when a transfer is aborted by the watchdog.

Function
REQ-016 The block SHALL implement states IDLE, BUSY and DONE.
REQ-017 IDLE: if any mX_valid is high, the block SHALL select one requester, register that requester's addr, wdata and wstrb into s_* outputs, set grant, and move to BUSY on the next edge.
REQ-018 Selection SHALL be round-robin: a lone requester wins; if both are valid, the winner is the requester that was not the last granted; after reset, m0 has priority.
REQ-019 BUSY: s_valid SHALL be 1 and the s_* command SHALL be held constant, even if requester inputs change.
REQ-020 BUSY with s_ready=1: on the same edge the block SHALL register s_rdata into the owner's rdata, assert the owner's ready for exactly the following cycle, drop s_valid and enter DONE.
REQ-021 The latency from s_ready high to mX_ready high SHALL be exactly 1 cycle; the non-owner's ready SHALL stay 0.
REQ-022 DONE SHALL last one cycle, then return to IDLE; requests are not sampled in DONE, so the owner's valid is not re-granted as it drops.
REQ-023 The minimum spacing between consecutive grants SHALL be 3 cycles (IDLE->BUSY->DONE); with both requesters continuously valid, grants SHALL alternate m0, m1, m0, ...
REQ-024 A 16-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without s_ready.
REQ-025 When the counter equals TIMEOUT-1 and s_ready is 0, the block SHALL act as on s_ready, except that rdata = ERR_RDATA; it SHALL also pulse timeout_err concurrently with the owner's ready.
REQ-026 If s_ready and the timeout condition coincide, s_ready SHALL take precedence: real s_rdata is returned and there is no timeout_err.
REQ-027 An s_ready arriving in IDLE or DONE SHALL be ignored.
REQ-028 mX_rdata SHALL hold its last value outside the ready pulse.
REQ-029 busy SHALL equal (state != IDLE).

Reset
REQ-030 Asserting resetn low SHALL immediately force: state IDLE; s_valid, m0_ready, m1_ready, timeout_err, busy = 0; s_addr, s_wdata, s_rdata copies, m0_rdata, m1_rdata = 0; s_wstrb = 0; grant = 0; priority to m0; counter = 0.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer, with no ready pulse on release.
REQ-032 The first grant after deassertion SHALL occur no earlier than the first clk edge with resetn high.

Structure
REQ-033 A shared package iomem_pkg SHALL hold the state encoding (IDLE=0, BUSY=1, DONE=2), the 32-bit data/address width constants, and the ERR_RDATA default.
REQ-034 The wait counter and its compare SHALL be a sub-module iomem_wdt (inputs clk, resetn, clear, enable; output expired); all other logic SHALL be inline.

Verification
REQ-035 Single read: m0 reads addr 32'h0300_0000 and the slave returns 32'h0000_003F with s_ready 2 cycles after s_valid -> m0_ready pulses 1 cycle after s_ready, m0_rdata = 32'h0000_003F, m1_ready stays 0.
REQ-036 Contention: m0 and m1 are both valid from reset and the slave has 1-cycle ready -> grant sequence 0,1,0,1; grants are 3 cycles apart.
REQ-037 Write hold: m1 writes 32'h1234_5678 with wstrb 4'hF to addr 32'h0600_0000, and m1_wdata changes during BUSY -> s_wdata stays 32'h1234_5678 until DONE.
REQ-038 Timeout: with TIMEOUT=8 and a slave that never readies -> s_valid is high for 8 cycles, the owner's ready and timeout_err pulse together, rdata = 32'hFFFF_FFFF.
REQ-039 Coincidence: s_ready arrives on the cycle the counter hits TIMEOUT-1 -> real data is returned and timeout_err = 0.
REQ-040 Reset mid-BUSY: resetn is pulled low for 1 cycle while in BUSY -> all outputs are 0 immediately and no stale ready pulse follows release.

Source files
------------

// File: rtl/iomem_pkg.sv
// iomem_pkg: shared widths, state encoding and error read-data default for the iomem arbiter
package iomem_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hFFFF_FFFF;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/iomem_wdt.sv
// iomem_wdt: 16-bit slave wait counter that flags when TIMEOUT-1 wait cycles have elapsed
module iomem_wdt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign cnt_d   = clear ? 16'd0 : enable ? cnt_q + 16'd1 : cnt_q;
    assign expired = cnt_q == 16'(TIMEOUT - 1);

    // count wait cycles, restarting at every new grant
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
endmodule

// File: rtl/iomem_arbiter.sv
// iomem_arbiter: round-robin arbiter of two requesters onto one iomem slave with a watchdog abort
module iomem_arbiter
    import iomem_pkg::*;
#(
    parameter int                TIMEOUT   = 255,
    parameter logic [DATA_W-1:0] ERR_RDATA = ERR_RDATA_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_valid,
    input  logic [3:0]        m0_wstrb,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_valid,
    input  logic [3:0]        m1_wstrb,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_valid,
    output logic [3:0]        s_wstrb,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              grant,
    output logic              busy,
    output logic              timeout_err
);
    logic [1:0]        state_q, state_d;
    logic              grant_q, grant_d;
    logic              pri_q, pri_d;
    logic              s_valid_q, s_valid_d;
    logic [3:0]        s_wstrb_q, s_wstrb_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              m0_ready_q, m0_ready_d;
    logic              m1_ready_q, m1_ready_d;
    logic              terr_q, terr_d;
    logic              sel, grab, fin, expired;
    logic [DATA_W-1:0] rd;

    // pri_q names the requester that wins a tie; a lone requester always wins
    assign sel  = (m0_valid & m1_valid) ? pri_q : m1_valid;
    assign grab = (state_q == ST_IDLE) & (m0_valid | m1_valid);
    assign fin  = (state_q == ST_BUSY) & (s_ready | expired);
    assign rd   = s_ready ? s_rdata : ERR_RDATA;

    iomem_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
        .clk    (clk),
        .resetn (resetn),
        .clear  (grab),
        .enable ((state_q == ST_BUSY) & ~s_ready),
        .expired(expired)
    );

    // next state: latch the winner's command on grant, complete on slave ready or watchdog
    always_comb begin
        state_d    = state_q == ST_IDLE ? (grab ? ST_BUSY : ST_IDLE) :
                     state_q == ST_BUSY ? (fin ? ST_DONE : ST_BUSY) : ST_IDLE;
        grant_d    = grab ? sel : grant_q;
        pri_d      = grab ? ~sel : pri_q;
        s_valid_d  = grab | (s_valid_q & ~fin);
        s_wstrb_d  = grab ? (sel ? m1_wstrb : m0_wstrb) : s_wstrb_q;
        s_addr_d   = grab ? (sel ? m1_addr : m0_addr) : s_addr_q;
        s_wdata_d  = grab ? (sel ? m1_wdata : m0_wdata) : s_wdata_q;
        m0_rdata_d = (fin & ~grant_q) ? rd : m0_rdata_q;
        m1_rdata_d = (fin & grant_q) ? rd : m1_rdata_q;
        m0_ready_d = fin & ~grant_q;
        m1_ready_d = fin & grant_q;
        terr_d     = fin & ~s_ready;
    end

    // state registers, all cleared by reset
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            pri_q      <= 1'b0;
            s_valid_q  <= 1'b0;
            s_wstrb_q  <= '0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            pri_q      <= pri_d;
            s_valid_q  <= s_valid_d;
            s_wstrb_q  <= s_wstrb_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            m0_ready_q <= m0_ready_d;
            m1_ready_q <= m1_ready_d;
            terr_q     <= terr_d;
        end

    assign m0_ready    = m0_ready_q;
    assign m1_ready    = m1_ready_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;
    assign s_valid     = s_valid_q;
    assign s_wstrb     = s_wstrb_q;
    assign s_addr      = s_addr_q;
    assign s_wdata     = s_wdata_q;
    assign grant       = grant_q;
    assign busy        = state_q != ST_IDLE;
    assign timeout_err = terr_q;
endmodule
